// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the ordered reset-release sequencer.
// Latency: n/a (declarations only). Backpressure: n/a.
// Contents: FSM state enum, stage index width, counter width helper.
package rst_seq_pkg;

   // Sequencer states. ERROR is only reachable when the ready timeout is built.
   typedef enum logic [2:0] {
      WAIT_POR   = 3'd0,
      DELAY      = 3'd1,
      WAIT_READY = 3'd2,
      RUN        = 3'd3,
      HOLD       = 3'd4,
      ERROR      = 3'd5
   } seq_state_t;

   // Stage index width; covers up to 8 sequenced resets.
   localparam int STG_IDX_W = 3;

   // Default ready-timeout length and the counter width it needs.
   localparam int DEF_TIMEOUT_CYCLES = 65535;
   localparam int TO_CNT_W           = $clog2(DEF_TIMEOUT_CYCLES + 1);

   // Width of a down-counter that must hold values 0..max_val.
   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable down-counter with a zero flag, used for delay/hold and ready timeout.
// Latency: load/decrement take effect on the next edge; o_zero reflects the register.
// Backpressure: none; a load always wins over a decrement, counting stops at 0.
//
// Ports:
//   clk_in   clock
//   rst_in   synchronous active-high reset (count -> 0)
//   i_load   load i_value this edge
//   i_value  value to load
//   i_dec    decrement this edge (ignored at 0)
//   o_zero   count is zero
module rst_seq_timer #(
   parameter int W = 16
) (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         i_load,
   input  logic [W-1:0] i_value,
   input  logic         i_dec,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_value;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/rst_sequencer.sv
// Ordered reset-release sequencer: releases NUM_STAGES resets one at a time after POR.
// Latency: stage k released D[k]+1 edges after DELAY entry; all outputs registered.
// Backpressure: each stage waits for its ready ack before the next is released.
//
// Optional feature macro: RST_SEQ_READY_TIMEOUT_EN (builds ready timeout + ERROR state;
// when undefined WAIT_READY waits forever and error_out/err_stage_out are tied to 0).
//
// Ports:
//   clk_in          clock
//   rst_in          synchronous active-high reset
//   por_done_in     upstream POR released and PLLs locked (synchronous)
//   sw_rst_req_in   one-cycle pulse requesting a full re-sequence
//   stage_delay_in  per-stage delay D[k] in bits [k*DELAY_W +: DELAY_W]
//   stage_ready_in  per-stage ready acknowledge (synchronous)
//   stage_rst_out   active-high per-stage reset
//   busy_out        sequencing in progress (DELAY, WAIT_READY, HOLD)
//   done_out        all stages released and ready
//   error_out       ready timeout occurred (sticky until re-sequence)
//   err_stage_out   index of the stage that timed out
module rst_sequencer
   import rst_seq_pkg::*;
#(
   parameter int NUM_STAGES     = 4,
   parameter int DELAY_W        = 16,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int HOLD_CYCLES    = 16
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic                          por_done_in,
   input  logic                          sw_rst_req_in,
   input  logic [NUM_STAGES*DELAY_W-1:0] stage_delay_in,
   input  logic [NUM_STAGES-1:0]         stage_ready_in,
   output logic [NUM_STAGES-1:0]         stage_rst_out,
   output logic                          busy_out,
   output logic                          done_out,
   output logic                          error_out,
   output logic [STG_IDX_W-1:0]          err_stage_out
);

   // The delay timer is shared between per-stage delays and the re-sequence hold.
   localparam int                     HOLD_W  = cnt_w(HOLD_CYCLES);
   localparam int                     CNT_W   = (DELAY_W > HOLD_W) ? DELAY_W : HOLD_W;
   localparam logic [STG_IDX_W-1:0]   LAST_K  = STG_IDX_W'(NUM_STAGES - 1);
   localparam logic [NUM_STAGES-1:0]  STG_LSB = NUM_STAGES'(1);

   seq_state_t                r_state;
   logic [STG_IDX_W-1:0]      r_k;
   logic [NUM_STAGES-1:0]     r_stage_rst;
   logic                      r_busy;
   logic                      r_done;
   logic                      r_por_q;

   logic [NUM_STAGES-1:0]     w_k_sel;
   logic                      w_rdy_k;
   logic [STG_IDX_W-1:0]      w_k_nxt;
   logic [DELAY_W-1:0]        w_d_first;
   logic [DELAY_W-1:0]        w_d_next;
   logic                      w_sw_req;
   logic                      w_por_go;
   logic                      w_dly_load;
   logic [CNT_W-1:0]          w_dly_val;
   logic                      w_dly_dec;
   logic                      w_dly_zero;

   assign w_k_sel   = STG_LSB << r_k;
   assign w_rdy_k   = |(stage_ready_in & w_k_sel);
   assign w_k_nxt   = r_k + STG_IDX_W'(1);
   assign w_d_first = stage_delay_in[DELAY_W-1:0];
   assign w_d_next  = stage_delay_in[int'(w_k_nxt) * DELAY_W +: DELAY_W];

   // Software request is ignored while still waiting for POR.
   assign w_sw_req  = sw_rst_req_in && (r_state != WAIT_POR);

   // Release from WAIT_POR needs the qualifier seen on two consecutive edges,
   // so the first DELAY entry lands one edge after the first sample of 1.
   assign w_por_go  = (r_state == WAIT_POR) && r_por_q;

   // Delay/hold timer control; conditions mirror the transitions into DELAY/HOLD.
   always_comb begin
      w_dly_load = 1'b0;
      w_dly_val  = '0;
      if (por_done_in) begin
         if (w_sw_req) begin
            // Loading HOLD_CYCLES-1 keeps HOLD occupied for exactly HOLD_CYCLES cycles.
            w_dly_load = 1'b1;
            w_dly_val  = CNT_W'(HOLD_CYCLES - 1);
         end else begin
            case (r_state)
               WAIT_POR: begin
                  if (w_por_go) begin
                     w_dly_load = 1'b1;
                     w_dly_val  = CNT_W'(w_d_first);
                  end
               end
               WAIT_READY: begin
                  if (w_rdy_k && (r_k != LAST_K)) begin
                     w_dly_load = 1'b1;
                     w_dly_val  = CNT_W'(w_d_next);
                  end
               end
               HOLD: begin
                  if (w_dly_zero) begin
                     w_dly_load = 1'b1;
                     w_dly_val  = CNT_W'(w_d_first);
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign w_dly_dec = (r_state == DELAY) || (r_state == HOLD);

   rst_seq_timer #(
      .W (CNT_W)
   ) u_dly_timer (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .i_load  (w_dly_load),
      .i_value (w_dly_val),
      .i_dec   (w_dly_dec),
      .o_zero  (w_dly_zero)
   );

`ifdef RST_SEQ_READY_TIMEOUT_EN
   localparam int TO_W = cnt_w(TIMEOUT_CYCLES);

   logic                 r_err;
   logic [STG_IDX_W-1:0] r_err_stage;
   logic                 w_to_load;
   logic                 w_to_dec;
   logic                 w_to_zero;

   // Armed on the edge that releases a stage, counts while waiting for its ready.
   assign w_to_load = por_done_in && !w_sw_req && (r_state == DELAY) && w_dly_zero;
   assign w_to_dec  = (r_state == WAIT_READY);

   rst_seq_timer #(
      .W (TO_W)
   ) u_to_timer (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .i_load  (w_to_load),
      .i_value (TO_W'(TIMEOUT_CYCLES)),
      .i_dec   (w_to_dec),
      .o_zero  (w_to_zero)
   );
`endif

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state     <= WAIT_POR;
         r_k         <= '0;
         r_stage_rst <= '1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_por_q     <= 1'b0;
`ifdef RST_SEQ_READY_TIMEOUT_EN
         r_err       <= 1'b0;
         r_err_stage <= '0;
`endif
      end else begin
         r_por_q <= por_done_in;
         if (!por_done_in) begin
            // Losing POR/PLL lock outranks software requests and timeouts.
            r_state     <= WAIT_POR;
            r_k         <= '0;
            r_stage_rst <= '1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef RST_SEQ_READY_TIMEOUT_EN
            r_err       <= 1'b0;
`endif
         end else if (w_sw_req) begin
            // Also restarts the hold count when already in HOLD.
            r_state     <= HOLD;
            r_k         <= '0;
            r_stage_rst <= '1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
`ifdef RST_SEQ_READY_TIMEOUT_EN
            r_err       <= 1'b0;
`endif
         end else begin
            case (r_state)
               WAIT_POR: begin
                  if (w_por_go) begin
                     r_state <= DELAY;
                     r_k     <= '0;
                     r_busy  <= 1'b1;
                  end
               end
               DELAY: begin
                  if (w_dly_zero) begin
                     r_stage_rst <= r_stage_rst & ~w_k_sel;
                     r_state     <= WAIT_READY;
                  end
               end
               WAIT_READY: begin
                  // Ready wins over a timeout expiring on the same edge.
                  if (w_rdy_k) begin
                     if (r_k != LAST_K) begin
                        r_k     <= w_k_nxt;
                        r_state <= DELAY;
                     end else begin
                        r_state <= RUN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end
                  end
`ifdef RST_SEQ_READY_TIMEOUT_EN
                  else if (w_to_zero) begin
                     // The failing stage goes back into reset; lower stages stay out.
                     r_state     <= ERROR;
                     r_stage_rst <= r_stage_rst | w_k_sel;
                     r_busy      <= 1'b0;
                     r_err       <= 1'b1;
                     r_err_stage <= r_k;
                  end
`endif
               end
               RUN: begin
                  // Later drops of stage ready are deliberately ignored.
               end
               HOLD: begin
                  if (w_dly_zero) begin
                     r_state <= DELAY;
                     r_k     <= '0;
                  end
               end
`ifdef RST_SEQ_READY_TIMEOUT_EN
               ERROR: begin
                  // Sticky until software re-sequence, POR loss or rst_in.
               end
`endif
               default: begin
                  r_state     <= WAIT_POR;
                  r_k         <= '0;
                  r_stage_rst <= '1;
                  r_busy      <= 1'b0;
                  r_done      <= 1'b0;
               end
            endcase
         end
      end
   end

   assign stage_rst_out = r_stage_rst;
   assign busy_out      = r_busy;
   assign done_out      = r_done;
`ifdef RST_SEQ_READY_TIMEOUT_EN
   assign error_out     = r_err;
   assign err_stage_out = r_err_stage;
`else
   assign error_out     = 1'b0;
   assign err_stage_out = '0;
`endif

endmodule

// File: tb/tb_rst_sequencer.sv
module tb_rst_sequencer;

   localparam int NS = 4;
   localparam int DW = 16;

   logic            clk_in = 1'b0;
   logic            rst_in = 1'b1;
   logic            por_done_in = 1'b0;
   logic            sw_rst_req_in = 1'b0;
   logic [NS*DW-1:0] stage_delay_in;
   logic [NS-1:0]   stage_ready_in = '0;
   logic [NS-1:0]   stage_rst_out;
   logic            busy_out;
   logic            done_out;
   logic            error_out;
   logic [2:0]      err_stage_out;

   rst_sequencer #(
      .NUM_STAGES     (NS),
      .DELAY_W        (DW),
      .TIMEOUT_CYCLES (20),
      .HOLD_CYCLES    (16)
   ) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .por_done_in    (por_done_in),
      .sw_rst_req_in  (sw_rst_req_in),
      .stage_delay_in (stage_delay_in),
      .stage_ready_in (stage_ready_in),
      .stage_rst_out  (stage_rst_out),
      .busy_out       (busy_out),
      .done_out       (done_out),
      .error_out      (error_out),
      .err_stage_out  (err_stage_out)
   );

   always #5 clk_in = ~clk_in;

   typedef enum {S_RST, S_BUSY, S_DONE, S_ERR, S_ESTG} sig_e;
   typedef enum {I_POR, I_SW, I_RDY, I_RST} in_e;
   typedef struct { int at; sig_e sig; int val; string tag; } exp_t;
   typedef struct { int at; in_e which; int val; } drv_t;

   exp_t sb[$];
   drv_t dq[$];
   int   dly[NS] = '{3, 0, 5, 1};
   int   edge_n = 0;
   int   n_chk = 0;
   int   n_err = 0;

   task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, edge_n);
      end
   endtask

   function automatic logic [31:0] sig_val(input sig_e s);
      case (s)
         S_RST:   return 32'(stage_rst_out);
         S_BUSY:  return 32'(busy_out);
         S_DONE:  return 32'(done_out);
         S_ERR:   return 32'(error_out);
         default: return 32'(err_stage_out);
      endcase
   endfunction

   task automatic ex(input int at, input sig_e s, input int v, input string tag);
      exp_t e;
      e.at = at; e.sig = s; e.val = v; e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic dr(input int at, input in_e w, input int v);
      drv_t d;
      d.at = at; d.which = w; d.val = v;
      dq.push_back(d);
   endtask

   // Observe 1 time unit after each edge, then drive what the next edge samples.
   task automatic step();
      @(posedge clk_in);
      edge_n++;
      #1;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].at == edge_n) begin
            chk_val(sb[i].tag, sig_val(sb[i].sig), 32'(sb[i].val));
            sb.delete(i);
         end
      end
      sw_rst_req_in = 1'b0;
      for (int i = dq.size() - 1; i >= 0; i--) begin
         if (dq[i].at == edge_n + 1) begin
            case (dq[i].which)
               I_POR:   por_done_in    = (dq[i].val != 0);
               I_SW:    sw_rst_req_in  = 1'b1;
               I_RDY:   stage_ready_in = NS'(dq[i].val);
               default: rst_in         = (dq[i].val != 0);
            endcase
            dq.delete(i);
         end
      end
   endtask

   task automatic run_to(input int t);
      while (edge_n < t) step();
   endtask

   // Full sequence from a DELAY(0) entry edge; each ready returns 2 edges after its release.
   task automatic plan_seq(input int e, input string p, output int t_end);
      int t;
      int f;
      t = e;
      ex(t, S_BUSY, 1, {p, " busy_entry"});
      for (int k = 0; k < NS; k++) begin
         f = t + dly[k] + 1;
         ex(f - 1, S_RST, (15 << k) & 15, $sformatf("%s rst_pre_k%0d", p, k));
         ex(f,     S_RST, (15 << (k + 1)) & 15, $sformatf("%s rst_rel_k%0d", p, k));
         dr(f + 2, I_RDY, (1 << (k + 1)) - 1);
         t = f + 2;
      end
      ex(t - 1, S_DONE, 0, {p, " done_pre"});
      ex(t,     S_DONE, 1, {p, " done"});
      ex(t,     S_BUSY, 0, {p, " busy_done"});
      t_end = t;
   endtask

   // Software request from RUN with ready cleared, back to DELAY(0) 16 edges later.
   task automatic sw_restart(input string p, output int s);
      s = edge_n + 2;
      dr(s, I_SW, 1);
      dr(s, I_RDY, 0);
      ex(s, S_RST, 15, {p, " sw_rst"});
      ex(s, S_BUSY, 1, {p, " sw_busy"});
      ex(s, S_DONE, 0, {p, " sw_done"});
   endtask

   int t, s, w;

   initial begin
      stage_delay_in = {16'd1, 16'd5, 16'd0, 16'd3};

      // Reset values
      ex(2, S_RST, 15, "reset rst");
      ex(2, S_BUSY, 0, "reset busy");
      ex(2, S_DONE, 0, "reset done");
      ex(2, S_ERR, 0, "reset err");
      ex(2, S_ESTG, 0, "reset estg");
      run_to(3);
      rst_in = 1'b0;

      // Nominal: POR sampled at edge 10, stage 0 released at edge 15
      ex(9, S_RST, 15, "waitpor rst");
      ex(9, S_BUSY, 0, "waitpor busy");
      dr(10, I_POR, 1);
      plan_seq(11, "nom", t);
      ex(15, S_RST, 14, "nom rst_k0_at15");
      run_to(t + 1);

      // Ready drop in RUN is ignored
      dr(t + 1, I_RDY, 0);
      ex(t + 4, S_DONE, 1, "run done_hold");
      ex(t + 4, S_RST, 0, "run rst_hold");
      run_to(t + 5);

      // Software re-sequence from RUN: 16-cycle hold, then nominal again
      sw_restart("hold", s);
      ex(s + 15, S_RST, 15, "hold rst_end");
      ex(s + 15, S_BUSY, 1, "hold busy_end");
      plan_seq(s + 16, "reseq", t);
      run_to(t + 1);

      // Second request during HOLD restarts the hold count
      sw_restart("rehold", s);
      dr(s + 5, I_SW, 1);
      ex(s + 5, S_BUSY, 1, "rehold busy");
      ex(s + 20, S_RST, 15, "rehold rst_still");
      plan_seq(s + 21, "rehold", t);
      run_to(t + 1);

      // POR loss during DELAY of stage 1, software request ignored in WAIT_POR
      sw_restart("porloss", s);
      dr(s + 22, I_RDY, 1);
      dr(s + 23, I_POR, 0);
      dr(s + 23, I_RDY, 0);
      ex(s + 22, S_RST, 14, "porloss rst_pre");
      ex(s + 22, S_BUSY, 1, "porloss busy_pre");
      ex(s + 23, S_RST, 15, "porloss rst");
      ex(s + 23, S_BUSY, 0, "porloss busy");
      ex(s + 23, S_DONE, 0, "porloss done");
      ex(s + 27, S_RST, 15, "porloss rst_wait");
      dr(s + 28, I_POR, 1);
      dr(s + 28, I_SW, 1);
      ex(s + 28, S_BUSY, 0, "waitpor sw_ignored");
      plan_seq(s + 29, "porup", t);
      run_to(t + 1);

      // Stage 2 ready withheld
      sw_restart("tmo", s);
      dr(s + 22, I_RDY, 1);
      dr(s + 25, I_RDY, 3);
      w = s + 31;
      ex(w, S_RST, 8, "tmo rst_rel2");
`ifdef RST_SEQ_READY_TIMEOUT_EN
      ex(w + 20, S_ERR, 0, "tmo err_pre");
      ex(w + 21, S_ERR, 1, "tmo err");
      ex(w + 21, S_ESTG, 2, "tmo estg");
      ex(w + 21, S_RST, 12, "tmo rst");
      ex(w + 21, S_BUSY, 0, "tmo busy");
      dr(w + 23, I_RDY, 7);
      ex(w + 25, S_ERR, 1, "tmo err_sticky");
      ex(w + 25, S_RST, 12, "tmo rst_sticky");
      run_to(w + 26);
      sw_restart("tmoclr", s);
      ex(s, S_ERR, 0, "tmoclr err");
      plan_seq(s + 16, "tmoclr", t);
`else
      ex(w + 21, S_ERR, 0, "notmo err");
      ex(w + 25, S_ERR, 0, "notmo err_late");
      ex(w + 25, S_RST, 8, "notmo rst");
      ex(w + 25, S_BUSY, 1, "notmo busy");
      dr(w + 27, I_RDY, 7);
      ex(w + 29, S_RST, 0, "notmo rst_rel3");
      ex(w + 30, S_ESTG, 0, "notmo estg");
      dr(w + 31, I_RDY, 15);
      ex(w + 31, S_DONE, 1, "notmo done");
      t = w + 31;
`endif
      run_to(t + 1);

      // Ready arrives on the same edge the timeout counter reaches zero
      sw_restart("tie", s);
      dr(s + 22, I_RDY, 1);
      dr(s + 25, I_RDY, 3);
      w = s + 31;
      dr(w + 21, I_RDY, 7);
      ex(w + 21, S_ERR, 0, "tie err");
      ex(w + 21, S_BUSY, 1, "tie busy");
      ex(w + 22, S_RST, 8, "tie rst_pre3");
      ex(w + 23, S_RST, 0, "tie rst_rel3");
      dr(w + 25, I_RDY, 15);
      ex(w + 25, S_DONE, 1, "tie done");
      ex(w + 25, S_ERR, 0, "tie err_end");
      run_to(w + 26);

      // Software request together with POR loss: WAIT_POR, not HOLD
      s = edge_n + 2;
      dr(s, I_SW, 1);
      dr(s, I_POR, 0);
      dr(s, I_RDY, 0);
      ex(s, S_RST, 15, "swpor rst");
      ex(s, S_BUSY, 0, "swpor busy");
      ex(s, S_DONE, 0, "swpor done");
      ex(s + 2, S_BUSY, 0, "swpor busy_wait");
      dr(s + 4, I_POR, 1);
      plan_seq(s + 5, "swpor", t);
      run_to(t + 1);

      // rst_in during WAIT_READY of stage 0
      sw_restart("midrst", s);
      ex(s + 21, S_RST, 14, "midrst rst_pre");
      ex(s + 21, S_BUSY, 1, "midrst busy_pre");
      dr(s + 22, I_RST, 1);
      ex(s + 22, S_RST, 15, "midrst rst");
      ex(s + 22, S_BUSY, 0, "midrst busy");
      ex(s + 22, S_DONE, 0, "midrst done");
      ex(s + 22, S_ERR, 0, "midrst err");
      dr(s + 23, I_RST, 0);
      plan_seq(s + 24, "midrst", t);
      run_to(t + 2);

      chk_val("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
